// File: rtl/multicore_sobel_cpu_1_oci_dct_ctrl.sv
// Packs 2-bit trace codes LSB-first into a 15-entry buffer and emits them as
// {count, buffer} frames over a valid/ready handshake, with flush and end-of-test control.
module multicore_sobel_cpu_1_oci_dct_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  in_code,
  output logic        in_ready,
  input  logic        flush,
  input  logic        test_ending,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [33:0] frame_data,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_has_ended,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ENTRIES = 15;

  state_t       state_reg;
  logic [29:0]  dct_buffer_reg;
  logic [3:0]   dct_count_reg;
  logic [33:0]  frame_data_reg;
  logic         frame_valid_reg;
  logic [15:0]  frame_cnt_reg;
  logic         ending_pending_reg;
  logic         test_has_ended_reg;

  logic         accept;
  logic [3:0]   count_next;
  logic [29:0]  buffer_next;
  logic         open_frame;
  logic         go_done;

  // in_ready depends on the state register alone, so the source never sees a
  // combinational loop through our inputs.
  assign in_ready   = (state_reg == FILL);
  assign accept     = in_valid && in_ready;
  assign count_next = dct_count_reg + {3'b000, accept};

  // Slot gi takes the incoming code only when it is the next free slot.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot
      assign buffer_next[2*gi +: 2] =
        (accept && (dct_count_reg == 4'(gi))) ? in_code : dct_buffer_reg[2*gi +: 2];
    end
  endgenerate

  // Frame decisions use the post-accept view so a same-cycle code is never lost.
  assign open_frame = (count_next != 4'd0) &&
                      (test_ending || flush || (count_next == 4'(ENTRIES)));
  assign go_done    = test_ending && (count_next == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= FILL;
      dct_buffer_reg     <= '0;
      dct_count_reg      <= '0;
      frame_data_reg     <= '0;
      frame_valid_reg    <= 1'b0;
      frame_cnt_reg      <= '0;
      ending_pending_reg <= 1'b0;
      test_has_ended_reg <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          dct_buffer_reg <= buffer_next;
          dct_count_reg  <= count_next;
          if (go_done) begin
            state_reg          <= DONE;
            test_has_ended_reg <= 1'b1;
          end else if (open_frame) begin
            state_reg       <= EMIT;
            frame_data_reg  <= {count_next, buffer_next};
            frame_valid_reg <= 1'b1;
            if (test_ending) begin
              ending_pending_reg <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (test_ending) begin
            ending_pending_reg <= 1'b1;
          end
          if (frame_ready) begin
            dct_buffer_reg  <= '0;
            dct_count_reg   <= '0;
            frame_valid_reg <= 1'b0;
            if (frame_cnt_reg != 16'hFFFF) begin
              frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            if (ending_pending_reg || test_ending) begin
              state_reg          <= DONE;
              test_has_ended_reg <= 1'b1;
            end else begin
              state_reg <= FILL;
            end
          end
        end
        DONE: begin
          state_reg <= DONE;
        end
        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

  assign frame_valid    = frame_valid_reg;
  assign frame_data     = frame_data_reg;
  assign dct_buffer     = dct_buffer_reg;
  assign dct_count      = dct_count_reg;
  assign test_has_ended = test_has_ended_reg;
  assign frame_cnt      = frame_cnt_reg;

endmodule

// File: tb/tb_multicore_sobel_cpu_1_oci_dct_ctrl.sv
// Directed scenarios plus randomized traffic, checked against a queue-based
// model of the trace packer.
module tb_multicore_sobel_cpu_1_oci_dct_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_code;
  logic        in_ready;
  logic        flush;
  logic        test_ending;
  logic        frame_valid;
  logic        frame_ready;
  logic [33:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
  logic [15:0] frame_cnt;

  multicore_sobel_cpu_1_oci_dct_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_code        (in_code),
    .in_ready       (in_ready),
    .flush          (flush),
    .test_ending    (test_ending),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .frame_data     (frame_data),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended),
    .frame_cnt      (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: codes waiting in the buffer, an outstanding frame, flags.
  logic [1:0]  m_codes[$];
  bit          m_have_frame = 0;
  logic [33:0] m_frame = '0;
  bit          m_ending = 0;
  bit          m_ended = 0;
  int          m_fcnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] m_pack();
    logic [29:0] p = '0;
    for (int i = 0; i < m_codes.size(); i++) p[2*i +: 2] = m_codes[i];
    return p;
  endfunction

  task automatic m_make_frame();
    logic [3:0] n = 4'(m_codes.size());
    m_frame = {n, m_pack()};
    m_have_frame = 1;
  endtask

  task automatic m_update(input bit v, input logic [1:0] c, input bit fl,
                          input bit te, input bit fr, input bit rst);
    if (rst) begin
      m_codes.delete();
      m_have_frame = 0;
      m_frame = '0;
      m_ending = 0;
      m_ended = 0;
      m_fcnt = 0;
    end else if (m_ended) begin
      // terminal: inputs ignored
    end else if (m_have_frame) begin
      if (te) m_ending = 1;
      if (fr) begin
        $display("[TB] frame %0d delivered: count=%0d data=%h", m_fcnt + 1, m_frame[33:30], m_frame);
        m_have_frame = 0;
        m_codes.delete();
        if (m_fcnt < 65535) m_fcnt++;
        if (m_ending) m_ended = 1;
      end
    end else begin
      if (v) m_codes.push_back(c);
      if (te) begin
        if (m_codes.size() > 0) begin
          m_ending = 1;
          m_make_frame();
        end else begin
          m_ended = 1;
        end
      end else if (m_codes.size() == 15 || (fl && m_codes.size() > 0)) begin
        m_make_frame();
      end
    end
  endtask

  task automatic compare_all();
    check("in_ready", 64'(in_ready), 64'(!m_ended && !m_have_frame));
    check("frame_valid", 64'(frame_valid), 64'(m_have_frame));
    if (m_have_frame) check("frame_data", 64'(frame_data), 64'(m_frame));
    check("dct_count", 64'(dct_count), 64'(m_codes.size()));
    check("dct_buffer", 64'(dct_buffer), 64'(m_pack()));
    check("test_has_ended", 64'(test_has_ended), 64'(m_ended));
    check("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare at negedge.
  task automatic step(input bit v, input logic [1:0] c, input bit fl,
                      input bit te, input bit fr, input bit rst);
    in_valid = v;
    in_code = c;
    flush = fl;
    test_ending = te;
    frame_ready = fr;
    reset = rst;
    @(posedge clk);
    m_update(v, c, fl, te, fr, rst);
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [1:0] c, input bit fr);
    step(1, c, 0, 0, fr, 0);
  endtask

  initial begin
    logic [29:0] packed15;
    logic [33:0] exp_frame;
    in_valid = 0; in_code = 0; flush = 0; test_ending = 0; frame_ready = 0; reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1);
    check("reset_frame_data", 64'(frame_data), 64'd0);
    check("ready_after_reset", 64'(in_ready), 64'd1);
    step(0, 0, 0, 0, 0, 0);

    // Full frame of 15 codes 0,1,2,3,...
    packed15 = '0;
    for (int i = 0; i < 15; i++) begin
      packed15[2*i +: 2] = 2'(i % 4);
      push(2'(i % 4), 0);
    end
    exp_frame = {4'd15, packed15};
    check("full_frame_valid", 64'(frame_valid), 64'd1);
    check("full_frame_data", 64'(frame_data), 64'(exp_frame));
    // Sink stalls for 5 cycles, then accepts.
    for (int i = 0; i < 5; i++) begin
      step(1, 2'(i), 1, 0, 0, 0);
      check("stall_data", 64'(frame_data), 64'(exp_frame));
      check("stall_ready", 64'(in_ready), 64'd0);
    end
    step(0, 0, 0, 0, 1, 0);
    check("full_frame_cnt", 64'(frame_cnt), 64'd1);

    // Codes 11,01,10 then flush.
    push(2'b11, 0); push(2'b01, 0); push(2'b10, 0);
    step(0, 0, 1, 0, 0, 0);
    exp_frame = {4'd3, 24'b0, 6'b10_01_11};
    check("flush_frame_data", 64'(frame_data), 64'(exp_frame));
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    check("flush_empty_ignored", 64'(frame_valid), 64'd0);

    // Count 4 then accept+flush together.
    for (int i = 0; i < 4; i++) push(2'd1, 0);
    step(1, 2'b10, 1, 0, 0, 0);
    check("same_cycle_count", 64'(frame_data[33:30]), 64'd5);
    check("same_cycle_code", 64'(frame_data[9:8]), 64'd2);
    step(0, 0, 0, 0, 1, 0);

    // Count 5 then test_ending.
    for (int i = 0; i < 5; i++) push(2'(i), 0);
    step(0, 0, 0, 1, 0, 0);
    check("end_frame_count", 64'(frame_data[33:30]), 64'd5);
    step(0, 0, 0, 0, 1, 0);
    check("ended", 64'(test_has_ended), 64'd1);
    for (int i = 0; i < 4; i++) step(1, 2'(i), 1, 1, 1, 0);
    check("ended_sticky_ready", 64'(in_ready), 64'd0);

    // test_ending at count 0.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    check("end_empty", 64'(test_has_ended), 64'd1);
    check("end_empty_noframe", 64'(frame_valid), 64'd0);

    // Reset with a frame pending.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) push(2'd3, 0);
    step(0, 0, 0, 0, 0, 1);
    check("rst_pending_valid", 64'(frame_valid), 64'd0);
    check("rst_pending_data", 64'(frame_data), 64'd0);
    check("rst_pending_ready", 64'(in_ready), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = ($urandom_range(0, 399) == 0) || (m_ended && $urandom_range(0, 19) == 0);
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 2) != 0, rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
